echo_request_arbiter: RTL and testbench
=======================================

ECHO_REQUEST_ARBITER -- requirements
Module: echo_request_arbiter

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 4, the maximum number of requests outstanding in the echo datapath (power of 2, 2..16).
REQ-002 SHALL have a single clock and an asynchronous, active-low reset, with all state clocked on CLK rising edge.
REQ-003 SHALL have port CLK  in  1  clock.
REQ-004 SHALL have port nRST  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports req0$say__ENA in 1, req0$say_meth in 32, req0$say_v in 32, req0$say__RDY out 1: requester 0 say method.
REQ-006 SHALL have ports req1$say__ENA, req1$say_meth, req1$say_v, req1$say__RDY, with widths as REQ-005: requester 1 say method.
REQ-007 SHALL have ports echo$say__ENA out 1, echo$say_meth out 32, echo$say_v out 32, echo$say__RDY in 1: issue to the echo request port.
REQ-008 SHALL have ports echo$heard__ENA in 1, echo$heard_meth in 32, echo$heard_v in 32, echo$heard__RDY out 1: response from the echo indication port.
REQ-009 SHALL have ports ind0$heard__ENA out 1, ind0$heard_meth out 32, ind0$heard_v out 32, ind0$heard__RDY in 1: response to requester 0.
REQ-010 SHALL have ports ind1$heard__ENA, ind1$heard_meth, ind1$heard_v, ind1$heard__RDY, with widths as REQ-009: response to requester 1.
REQ-011 SHALL have port proto_err  out  1  sticky flag for a heard response with no outstanding tag.

Function
REQ-012 SHALL complete a transfer only in a cycle where the method's ENA and RDY are both 1; an ENA without RDY SHALL be ignored.
REQ-013 SHALL hold one 64-bit holding buffer per requester (valid_k, meth_k, v_k); reqk$say__RDY = !valid_k.
REQ-014 SHALL load a buffer and set valid_k on an accepted say; the data becomes eligible for issue in the following cycle (minimum latency 1 cycle, accept-to-echo$say__ENA).
REQ-015 SHALL keep a round-robin pointer last (1 bit, the last issued source). If both buffers are valid, the source != last is selected; if one is valid, that source is selected.
REQ-016 SHALL drive echo$say__ENA = (valid_0 | valid_1) & echo$say__RDY & !tag_full, with echo$say_meth/v taken from the selected buffer; meth/v SHALL be 0 when no buffer is valid.
REQ-017 SHALL, on issue: clear valid of the selected buffer, set last = selected source, and push the source id into the tag FIFO.
REQ-018 SHALL implement the tag FIFO as depth TAG_DEPTH, 1-bit entries, with wrap-around read/write pointers and a count of width log2(TAG_DEPTH)+1. tag_full = (count == TAG_DEPTH); tag_empty = (count == 0).
REQ-019 SHALL block a push when tag_full even if a pop occurs in the same cycle; a simultaneous push and pop with !tag_full SHALL leave count unchanged.
REQ-020 SHALL drive echo$heard__RDY = !tag_empty & indH$heard__RDY, where H = FIFO head.
REQ-021 SHALL drive indk$heard__ENA = echo$heard__ENA & echo$heard__RDY & (H == k), combinationally; indk meth/v SHALL pass echo$heard meth/v unchanged when selected and be 0 otherwise.
REQ-022 SHALL pop the head on a completed heard transfer; responses return in issue order.
REQ-023 SHALL set proto_err, and perform no pop or routing, on echo$heard__ENA while tag_empty; proto_err stays set until reset.
REQ-024 SHALL allow a buffer to accept new data in the cycle after its issue edge (max 1 accept per 2 cycles per port; 1 issue per cycle aggregate).

Reset
REQ-025 SHALL, while nRST = 0 (asynchronously), clear valid_0/1, meth/v buffers, FIFO pointers, count and proto_err; last SHALL reset to 1 so requester 0 wins the first tie.
REQ-026 SHALL drive the following output values in reset: reqk$say__RDY = 1; echo$say__ENA, echo$heard__RDY, indk$heard__ENA = 0; all data outputs = 0.
REQ-027 SHALL discard, on reset mid-operation, all buffered requests and outstanding tags; no indication SHALL fire for pre-reset requests.

Verification
REQ-028 SHALL be verified by: both reqs say in the same cycle (meth=1 v=0xA / meth=2 v=0xB), echo$say__RDY=1 -> echo issues 0xA then 0xB on consecutive cycles, and heard responses route to ind0 then ind1.
REQ-029 SHALL be verified by: req0 only, 5 say transfers, echo$say__RDY=1, no heard responses -> 4 issue, then echo$say__ENA=0 with the 5th held; one heard response -> 5th issues in the next cycle.
REQ-030 SHALL be verified by: ind1$heard__RDY=0 with head tag=1 -> echo$heard__RDY=0; raising ind1$heard__RDY -> a transfer with data unchanged.
REQ-031 SHALL be verified by: echo$heard__ENA pulse after reset (FIFO empty) -> proto_err=1, no indk$heard__ENA, flag persists.
REQ-032 SHALL be verified by: nRST asserted asynchronously mid-cycle with 2 tags outstanding -> outputs reach reset values before the next edge; later heard responses set proto_err.
REQ-033 SHALL be verified by: 3 alternating saturation rounds with both ports continuously offering -> grant order 0,1,0,1,0,1 and FIFO wraps with no loss.

Source files
------------

// File: rtl/echo_request_arbiter.sv
// Two-requester round-robin arbiter in front of a single echo request port.
// The echo indication path is routed back to the originating requester
// using a tag FIFO that records the source id of every issued request.
// The FIFO is needed because responses come back in issue order.
module echo_request_arbiter #(
  parameter int TAG_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        nRST,

  input  logic        req0_say__ENA,
  input  logic [31:0] req0_say_meth,
  input  logic [31:0] req0_say_v,
  output logic        req0_say__RDY,

  input  logic        req1_say__ENA,
  input  logic [31:0] req1_say_meth,
  input  logic [31:0] req1_say_v,
  output logic        req1_say__RDY,

  output logic        echo_say__ENA,
  output logic [31:0] echo_say_meth,
  output logic [31:0] echo_say_v,
  input  logic        echo_say__RDY,

  input  logic        echo_heard__ENA,
  input  logic [31:0] echo_heard_meth,
  input  logic [31:0] echo_heard_v,
  output logic        echo_heard__RDY,

  output logic        ind0_heard__ENA,
  output logic [31:0] ind0_heard_meth,
  output logic [31:0] ind0_heard_v,
  input  logic        ind0_heard__RDY,

  output logic        ind1_heard__ENA,
  output logic [31:0] ind1_heard_meth,
  output logic [31:0] ind1_heard_v,
  input  logic        ind1_heard__RDY,

  output logic        proto_err
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

  // Holding buffers, one per requester
  logic [1:0]        valid_q, valid_d;
  logic [1:0][31:0]  meth_q, meth_d;
  logic [1:0][31:0]  v_q, v_d;
  logic              last_q, last_d;

  // Tag FIFO: each entry is the source id of an issued request
  logic [TAG_DEPTH-1:0] tags_q, tags_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic proto_err_q, proto_err_d;

  // Combinational helpers
  logic [1:0]       req_ena;
  logic [1:0][31:0] req_meth;
  logic [1:0][31:0] req_v;
  logic [1:0]       req_acc;
  logic             any_valid;
  logic             sel;
  logic             tag_full;
  logic             tag_empty;
  logic             issue;
  logic             head;
  logic             head_rdy;
  logic             heard_xfer;
  logic             route0;
  logic             route1;

  assign req_ena  = {req1_say__ENA, req0_say__ENA};
  assign req_meth = {req1_say_meth, req0_say_meth};
  assign req_v    = {req1_say_v,    req0_say_v};

  // Request acceptance, round-robin source select and issue qualification
  always_comb begin
    req_acc   = req_ena & ~valid_q;
    any_valid = |valid_q;
    // On a tie the source that did not issue last wins; otherwise the single
    // valid source is chosen (valid_q[1] is 0 when only buffer 0 is valid).
    sel       = (valid_q == 2'b11) ? ~last_q : valid_q[1];
    tag_full  = (count_q == FULL_CNT);
    tag_empty = (count_q == '0);
    issue     = any_valid & echo_say__RDY & ~tag_full;
  end

  // Response routing driven by the tag at the FIFO head
  always_comb begin
    head       = tags_q[rd_ptr_q];
    head_rdy   = head ? ind1_heard__RDY : ind0_heard__RDY;
    heard_xfer = echo_heard__ENA & ~tag_empty & head_rdy;
    route0     = ~tag_empty & ~head;
    route1     = ~tag_empty & head;
  end

  // Output drive
  always_comb begin
    req0_say__RDY   = ~valid_q[0];
    req1_say__RDY   = ~valid_q[1];

    echo_say__ENA   = issue;
    echo_say_meth   = any_valid ? meth_q[sel] : '0;
    echo_say_v      = any_valid ? v_q[sel]    : '0;

    echo_heard__RDY = ~tag_empty & head_rdy;

    ind0_heard__ENA = heard_xfer & ~head;
    ind0_heard_meth = route0 ? echo_heard_meth : '0;
    ind0_heard_v    = route0 ? echo_heard_v    : '0;

    ind1_heard__ENA = heard_xfer & head;
    ind1_heard_meth = route1 ? echo_heard_meth : '0;
    ind1_heard_v    = route1 ? echo_heard_v    : '0;

    proto_err       = proto_err_q;
  end

  // Next state for holding buffers and round-robin pointer
  always_comb begin
    valid_d = valid_q;
    meth_d  = meth_q;
    v_d     = v_q;
    last_d  = last_q;

    // A buffer can never be accepted and issued in the same cycle: accept
    // needs it empty, issue needs it full.
    if (issue) begin
      valid_d[sel] = 1'b0;
      last_d       = sel;
    end

    for (int k = 0; k < 2; k++) begin
      if (req_acc[k]) begin
        valid_d[k] = 1'b1;
        meth_d[k]  = req_meth[k];
        v_d[k]     = req_v[k];
      end
    end
  end

  // Next state for the tag FIFO and protocol error flag
  always_comb begin
    tags_d      = tags_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    proto_err_d = proto_err_q | (echo_heard__ENA & tag_empty);

    // issue already excludes the full case, so a pop in the same cycle
    // cannot sneak a push past a full FIFO.
    if (issue) begin
      tags_d[wr_ptr_q] = sel;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end

    if (heard_xfer) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({issue, heard_xfer})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; last resets to 1 so requester 0 wins the first tie
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q     <= '0;
      meth_q      <= '0;
      v_q         <= '0;
      last_q      <= 1'b1;
      tags_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      meth_q      <= meth_d;
      v_q         <= v_d;
      last_q      <= last_d;
      tags_q      <= tags_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_echo_request_arbiter.sv
// Directed bench for echo_request_arbiter. Inputs change just after the
// falling edge and outputs are checked 1ns later, away from the rising edge.
module tb_echo_request_arbiter;

  logic        CLK;
  logic        nRST;
  logic        req0_say__ENA;
  logic [31:0] req0_say_meth;
  logic [31:0] req0_say_v;
  logic        req0_say__RDY;
  logic        req1_say__ENA;
  logic [31:0] req1_say_meth;
  logic [31:0] req1_say_v;
  logic        req1_say__RDY;
  logic        echo_say__ENA;
  logic [31:0] echo_say_meth;
  logic [31:0] echo_say_v;
  logic        echo_say__RDY;
  logic        echo_heard__ENA;
  logic [31:0] echo_heard_meth;
  logic [31:0] echo_heard_v;
  logic        echo_heard__RDY;
  logic        ind0_heard__ENA;
  logic [31:0] ind0_heard_meth;
  logic [31:0] ind0_heard_v;
  logic        ind0_heard__RDY;
  logic        ind1_heard__ENA;
  logic [31:0] ind1_heard_meth;
  logic [31:0] ind1_heard_v;
  logic        ind1_heard__RDY;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  // Saturation table: per cycle inputs and expected outputs
  logic        s_r0e [9];
  logic [31:0] s_r0v [9];
  logic        s_r1e [9];
  logic [31:0] s_r1v [9];
  logic        s_he  [9];
  logic        s_ee  [9];
  logic [31:0] s_ev  [9];
  logic        s_i0  [9];
  logic        s_i1  [9];

  echo_request_arbiter #(.TAG_DEPTH(4)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .req0_say__ENA   (req0_say__ENA),
    .req0_say_meth   (req0_say_meth),
    .req0_say_v      (req0_say_v),
    .req0_say__RDY   (req0_say__RDY),
    .req1_say__ENA   (req1_say__ENA),
    .req1_say_meth   (req1_say_meth),
    .req1_say_v      (req1_say_v),
    .req1_say__RDY   (req1_say__RDY),
    .echo_say__ENA   (echo_say__ENA),
    .echo_say_meth   (echo_say_meth),
    .echo_say_v      (echo_say_v),
    .echo_say__RDY   (echo_say__RDY),
    .echo_heard__ENA (echo_heard__ENA),
    .echo_heard_meth (echo_heard_meth),
    .echo_heard_v    (echo_heard_v),
    .echo_heard__RDY (echo_heard__RDY),
    .ind0_heard__ENA (ind0_heard__ENA),
    .ind0_heard_meth (ind0_heard_meth),
    .ind0_heard_v    (ind0_heard_v),
    .ind0_heard__RDY (ind0_heard__RDY),
    .ind1_heard__ENA (ind1_heard__ENA),
    .ind1_heard_meth (ind1_heard_meth),
    .ind1_heard_v    (ind1_heard_v),
    .ind1_heard__RDY (ind1_heard__RDY),
    .proto_err       (proto_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy0"},   {31'd0, req0_say__RDY},   32'd1);
    chk({tag, "_rdy1"},   {31'd0, req1_say__RDY},   32'd1);
    chk({tag, "_say_en"}, {31'd0, echo_say__ENA},   32'd0);
    chk({tag, "_say_m"},  echo_say_meth,            32'd0);
    chk({tag, "_say_v"},  echo_say_v,               32'd0);
    chk({tag, "_hrd_rdy"},{31'd0, echo_heard__RDY}, 32'd0);
    chk({tag, "_ind0_en"},{31'd0, ind0_heard__ENA}, 32'd0);
    chk({tag, "_ind1_en"},{31'd0, ind1_heard__ENA}, 32'd0);
    chk({tag, "_ind0_v"}, ind0_heard_v,             32'd0);
    chk({tag, "_ind1_v"}, ind1_heard_v,             32'd0);
    chk({tag, "_perr"},   {31'd0, proto_err},       32'd0);
  endtask

  initial begin
    nRST            = 1'b0;
    req0_say__ENA   = 1'b0;
    req0_say_meth   = '0;
    req0_say_v      = '0;
    req1_say__ENA   = 1'b0;
    req1_say_meth   = '0;
    req1_say_v      = '0;
    echo_say__RDY   = 1'b1;
    echo_heard__ENA = 1'b0;
    echo_heard_meth = '0;
    echo_heard_v    = '0;
    ind0_heard__RDY = 1'b1;
    ind1_heard__RDY = 1'b1;

    //                 0          1          2          3          4          5          6          7     8
    s_r0e = '{1'b1,      1'b1,      1'b1,      1'b1,      1'b1,      1'b1,      1'b0,      1'b0, 1'b0};
    s_r0v = '{32'hA00,   32'hA01,   32'hA01,   32'hA02,   32'hA02,   32'hA03,   32'h0,     32'h0, 32'h0};
    s_r1e = '{1'b1,      1'b1,      1'b1,      1'b1,      1'b1,      1'b1,      1'b1,      1'b0, 1'b0};
    s_r1v = '{32'hB00,   32'hB01,   32'hB01,   32'hB01,   32'hB02,   32'hB02,   32'hB03,   32'h0, 32'h0};
    s_he  = '{1'b0,      1'b0,      1'b1,      1'b1,      1'b1,      1'b1,      1'b1,      1'b1, 1'b0};
    s_ee  = '{1'b0,      1'b1,      1'b1,      1'b1,      1'b1,      1'b1,      1'b1,      1'b0, 1'b0};
    s_ev  = '{32'h0,     32'hA00,   32'hB00,   32'hA01,   32'hB01,   32'hA02,   32'hB02,   32'h0, 32'h0};
    s_i0  = '{1'b0,      1'b0,      1'b1,      1'b0,      1'b1,      1'b0,      1'b1,      1'b0, 1'b0};
    s_i1  = '{1'b0,      1'b0,      1'b0,      1'b1,      1'b0,      1'b1,      1'b0,      1'b1, 1'b0};

    // Reset values
    step(); step(); #1;
    chk_reset_outputs("rst");
    step();
    nRST = 1'b1;

    // Heard with empty tag FIFO: flag sets, nothing routed, flag sticks
    step();
    echo_heard__ENA = 1'b1; echo_heard_meth = 32'h55; echo_heard_v = 32'h66;
    #1;
    chk("perr_ind0_en", {31'd0, ind0_heard__ENA}, 32'd0);
    chk("perr_ind1_en", {31'd0, ind1_heard__ENA}, 32'd0);
    chk("perr_hrd_rdy", {31'd0, echo_heard__RDY}, 32'd0);
    step();
    echo_heard__ENA = 1'b0;
    #1;
    chk("perr_set", {31'd0, proto_err}, 32'd1);
    step(); #1;
    chk("perr_sticky", {31'd0, proto_err}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("perr_clr", {31'd0, proto_err}, 32'd0);
    step();
    nRST = 1'b1;

    // Simultaneous says; requester 0 wins the first tie
    step();
    req0_say__ENA = 1'b1; req0_say_meth = 32'd1; req0_say_v = 32'hA;
    req1_say__ENA = 1'b1; req1_say_meth = 32'd2; req1_say_v = 32'hB;
    #1;
    chk("tie_no_issue", {31'd0, echo_say__ENA}, 32'd0);
    step();
    req0_say__ENA = 1'b0; req1_say__ENA = 1'b0;
    #1;
    chk("tie_en0",  {31'd0, echo_say__ENA}, 32'd1);
    chk("tie_m0",   echo_say_meth, 32'd1);
    chk("tie_v0",   echo_say_v,    32'hA);
    chk("tie_rdy0", {31'd0, req0_say__RDY}, 32'd0);
    step(); #1;
    chk("tie_en1",  {31'd0, echo_say__ENA}, 32'd1);
    chk("tie_m1",   echo_say_meth, 32'd2);
    chk("tie_v1",   echo_say_v,    32'hB);
    chk("tie_rdy0b",{31'd0, req0_say__RDY}, 32'd1);
    step();
    echo_heard__ENA = 1'b1; echo_heard_meth = 32'h7; echo_heard_v = 32'h70;
    #1;
    chk("tie_idle",    {31'd0, echo_say__ENA}, 32'd0);
    chk("tie_idle_v",  echo_say_v, 32'd0);
    chk("tie_h0_en0",  {31'd0, ind0_heard__ENA}, 32'd1);
    chk("tie_h0_en1",  {31'd0, ind1_heard__ENA}, 32'd0);
    chk("tie_h0_m",    ind0_heard_meth, 32'h7);
    chk("tie_h0_v",    ind0_heard_v,    32'h70);
    chk("tie_h0_v1z",  ind1_heard_v,    32'h0);
    step();
    echo_heard_meth = 32'h8; echo_heard_v = 32'h80;
    #1;
    chk("tie_h1_en1",  {31'd0, ind1_heard__ENA}, 32'd1);
    chk("tie_h1_en0",  {31'd0, ind0_heard__ENA}, 32'd0);
    chk("tie_h1_v",    ind1_heard_v, 32'h80);
    chk("tie_h1_v0z",  ind0_heard_v, 32'h0);
    step();
    echo_heard__ENA = 1'b0;
    #1;
    chk("tie_empty", {31'd0, echo_heard__RDY}, 32'd0);

    // Tag FIFO fills after four issues; fifth request is held
    for (int i = 0; i < 4; i++) begin
      step();
      req0_say__ENA = 1'b1; req0_say_meth = 32'h10 + i; req0_say_v = 32'h100 + i;
      #1;
      chk("full_rdy", {31'd0, req0_say__RDY}, 32'd1);
      step();
      req0_say__ENA = 1'b0;
      #1;
      chk("full_issue_en", {31'd0, echo_say__ENA}, 32'd1);
      chk("full_issue_v",  echo_say_v, 32'h100 + i);
    end
    step();
    req0_say__ENA = 1'b1; req0_say_meth = 32'h14; req0_say_v = 32'h104;
    step();
    req0_say__ENA = 1'b0;
    #1;
    chk("full_block_en", {31'd0, echo_say__ENA}, 32'd0);
    chk("full_block_v",  echo_say_v, 32'h104);
    chk("full_block_rdy",{31'd0, req0_say__RDY}, 32'd0);
    step(); #1;
    chk("full_block_en2", {31'd0, echo_say__ENA}, 32'd0);
    step();
    echo_heard__ENA = 1'b1; echo_heard_v = 32'h90;
    #1;
    chk("full_pop_ind0", {31'd0, ind0_heard__ENA}, 32'd1);
    chk("full_pop_noiss",{31'd0, echo_say__ENA}, 32'd0);
    step();
    echo_heard__ENA = 1'b0;
    #1;
    chk("full_fifth_en", {31'd0, echo_say__ENA}, 32'd1);
    chk("full_fifth_v",  echo_say_v, 32'h104);
    for (int i = 0; i < 4; i++) begin
      step();
      echo_heard__ENA = 1'b1; echo_heard_v = 32'h91 + i;
      #1;
      chk("full_drain_ind0", {31'd0, ind0_heard__ENA}, 32'd1);
    end
    step();
    echo_heard__ENA = 1'b0;
    #1;
    chk("full_drained", {31'd0, echo_heard__RDY}, 32'd0);

    // Head tag 1 with ind1 stalled, then released
    step();
    req1_say__ENA = 1'b1; req1_say_meth = 32'h3; req1_say_v = 32'h33;
    step();
    req1_say__ENA = 1'b0;
    #1;
    chk("bp_issue_v", echo_say_v, 32'h33);
    step();
    ind1_heard__RDY = 1'b0;
    echo_heard__ENA = 1'b1; echo_heard_meth = 32'hAB; echo_heard_v = 32'hCD;
    #1;
    chk("bp_hrd_rdy0", {31'd0, echo_heard__RDY}, 32'd0);
    chk("bp_ind1_en0", {31'd0, ind1_heard__ENA}, 32'd0);
    step();
    ind1_heard__RDY = 1'b1;
    #1;
    chk("bp_hrd_rdy1", {31'd0, echo_heard__RDY}, 32'd1);
    chk("bp_ind1_en1", {31'd0, ind1_heard__ENA}, 32'd1);
    chk("bp_ind0_en",  {31'd0, ind0_heard__ENA}, 32'd0);
    chk("bp_ind1_m",   ind1_heard_meth, 32'hAB);
    chk("bp_ind1_v",   ind1_heard_v,    32'hCD);
    step();
    echo_heard__ENA = 1'b0;
    #1;
    chk("bp_empty", {31'd0, echo_heard__RDY}, 32'd0);
    chk("bp_perr",  {31'd0, proto_err}, 32'd0);

    // Saturation: both ports always offering, responses drained every cycle
    for (int t = 0; t < 9; t++) begin
      step();
      req0_say__ENA = s_r0e[t]; req0_say_meth = 32'd0; req0_say_v = s_r0v[t];
      req1_say__ENA = s_r1e[t]; req1_say_meth = 32'd1; req1_say_v = s_r1v[t];
      echo_heard__ENA = s_he[t]; echo_heard_v = 32'hE0 + t;
      #1;
      chk($sformatf("sat%0d_en", t),   {31'd0, echo_say__ENA},   {31'd0, s_ee[t]});
      chk($sformatf("sat%0d_v", t),    echo_say_v,               s_ev[t]);
      chk($sformatf("sat%0d_ind0", t), {31'd0, ind0_heard__ENA}, {31'd0, s_i0[t]});
      chk($sformatf("sat%0d_ind1", t), {31'd0, ind1_heard__ENA}, {31'd0, s_i1[t]});
    end
    #1;
    chk("sat_perr", {31'd0, proto_err}, 32'd0);

    // Asynchronous reset with two tags outstanding
    step();
    req0_say__ENA = 1'b1; req0_say_meth = 32'd1; req0_say_v = 32'h51;
    req1_say__ENA = 1'b1; req1_say_meth = 32'd2; req1_say_v = 32'h52;
    step();
    req0_say__ENA = 1'b0; req1_say__ENA = 1'b0;
    #1;
    chk("ar_v0", echo_say_v, 32'h51);
    step(); #1;
    chk("ar_v1", echo_say_v, 32'h52);
    step(); #1;
    chk("ar_outstanding", {31'd0, echo_heard__RDY}, 32'd1);
    #1;
    nRST = 1'b0;
    #1;
    chk_reset_outputs("ar");
    step();
    nRST = 1'b1;
    step();
    echo_heard__ENA = 1'b1; echo_heard_v = 32'h77;
    #1;
    chk("ar_ind0_en", {31'd0, ind0_heard__ENA}, 32'd0);
    chk("ar_ind1_en", {31'd0, ind1_heard__ENA}, 32'd0);
    step();
    echo_heard__ENA = 1'b0;
    #1;
    chk("ar_perr", {31'd0, proto_err}, 32'd1);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
